comb3_feeder: RTL and testbench
===============================

# comb3_feeder

Upstream operand stage for the `comb3` combinational unit. Accepts 4-bit operand pairs over a valid/ready handshake and buffers them in a small show-ahead FIFO. Presents the head pair on `out_a`/`out_b`, which wire directly to `comb3`'s `A`/`B`. Decouples the operand producer from the consumer that samples `comb3`'s `O`, and reports occupancy and producer stall cycles.

## Interface
- `WIDTH`, 4, operand width; matches `comb3` `A`/`B`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 8, width of the saturating stall counter.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of FIFO contents.
- `in_valid` input 1: producer offers `in_a`/`in_b`.
- `in_ready` output 1: FIFO can accept a pair this cycle.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `out_valid` output 1: head pair is valid on `out_a`/`out_b`.
- `out_ready` input 1: consumer takes the head pair this cycle.
- `out_a` output WIDTH: head operand A, feeds `comb3.A`.
- `out_b` output WIDTH: head operand B, feeds `comb3.B`.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `stall_cnt` output CNT_W: cycles with `in_valid && !in_ready`; saturates at all-ones.

## Operation
- Push happens when `in_valid && in_ready` on the clock edge. Pop happens when `out_valid && out_ready`.
- `in_ready = (level != DEPTH)`. It depends only on registered state and never on `out_ready`. When full, a same-cycle pop does not enable a push.
- `out_valid = (level != 0)`.
- `out_a`/`out_b` show `mem[rd_ptr]` while `out_valid`, and are forced to 0 when empty.
- The head pair holds stable while `out_valid && !out_ready`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally modulo DEPTH. `level` is tracked explicitly: +1 on push only, −1 on pop only, unchanged on push+pop.
- Simultaneous push and pop with 0 < `level` < DEPTH: both pointers advance and `level` is unchanged.
- `flush`:
  - Sets both pointers and `level` to 0 on the next edge.
  - Overrides any push or pop in that cycle; the offered pair is dropped.
  - `stall_cnt` is not cleared.
- `stall_cnt` increments each cycle with `in_valid && !in_ready`, holds at 2^CNT_W−1, and clears only on reset.
- Reset (`rst_n` low, asynchronous):
  - `level`=0, pointers=0, `stall_cnt`=0.
  - `out_valid`=0, `out_a`=`out_b`=0, `in_ready`=1.
  - Storage array is not reset. A reset mid-transfer discards all entries.
- No state machine beyond the pointer/level registers.

## Timing
- Write-to-output latency is 1 cycle. A pair pushed at edge N appears with `out_valid`=1 after edge N. `comb3.O` is valid combinationally in that same cycle.
- Throughput is one pair per cycle in each direction when 0 < `level` < DEPTH.
- Full-to-accept bubble: when full, `in_ready` rises in the cycle after the first pop.
- `rst_n` deassertion is used as-is (integration supplies a synchronised deassert). The first push can occur on the first edge with `rst_n`=1.

## Structure
- Package `comb3_pkg`:
  - `OP_W`=4.
  - `operand_pair_t` (packed `{a, b}`, 2×OP_W).
  - Default `DEPTH`.
- Storage lives in sub-module `comb3_fifo_mem`: a DEPTH×(2·WIDTH) register array with synchronous write and asynchronous read by index.
- Pointers, level, flush logic and the stall counter stay in `comb3_feeder`.
- Top-level integration: `comb3_feeder.out_a/out_b` → `comb3.A/B`. The consumer samples `comb3.O` qualified by `out_valid` and drives `out_ready`.

## Test plan
- Reset, then push (A,B)=(4'hF,4'h2) with `out_ready`=0:
  - After 1 edge: `out_valid`=1, `out_a`=F, `out_b`=2, `level`=1.
  - Output holds for 3 further cycles.
- Push 4 pairs (1,1),(2,2),(3,3),(4,4) with `out_ready`=0:
  - `level`=4, `in_ready`=0.
  - Hold `in_valid` 5 more cycles: `stall_cnt`=5 and the 5th pair is not stored.
- FIFO full, `out_ready`=1 for 4 cycles: pops 1,2,3,4 in order, then `out_valid`=0 and `out_a`=`out_b`=0.
- `level`=2, streaming push+pop every cycle for 8 cycles with A=B=k: `level` stays 2, output order is exact, and pointers wrap twice.
- `level`=3, `flush` with simultaneous `in_valid`: next cycle `level`=0, `out_valid`=0, `in_ready`=1, and the offered pair is absent.
- `rst_n` pulsed low mid-cycle with `level`=3:
  - Outputs go to reset values immediately without waiting for `clk`.
  - After release, a push of (7,9) appears at the head.

Source files
------------

// File: rtl/comb3_pkg.sv
// Shared types and defaults for the comb3 operand feeder.
package comb3_pkg;

   localparam int unsigned OP_W       = 4;
   localparam int unsigned FIFO_DEPTH = 4;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } operand_pair_t;

endpackage

// File: rtl/comb3_feeder_if.sv
// Producer/consumer handshake bundle around the comb3 operand FIFO.
interface comb3_feeder_if
   import comb3_pkg::*;
#(
   parameter int unsigned WIDTH = OP_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_a, out_b
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_a, out_b
   );

endinterface

// File: rtl/comb3_fifo_mem.sv
// Operand-pair storage: synchronous write, asynchronous indexed read, no reset.
module comb3_fifo_mem #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [PTR_W-1:0]   i_waddr,
   input  logic [2*WIDTH-1:0] i_wdata,
   input  logic [PTR_W-1:0]   i_raddr,
   output logic [2*WIDTH-1:0] o_rdata
);

   logic [2*WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/comb3_feeder.sv
// Show-ahead operand FIFO feeding comb3 A/B, with occupancy and stall reporting.
module comb3_feeder
   import comb3_pkg::*;
#(
   parameter int unsigned WIDTH = OP_W,
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = PTR_W + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   comb3_feeder_if.slave     io_bus,
   output logic [LVL_W-1:0]  o_level,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]   r_level;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_push;
   logic               w_pop;
   logic [2*WIDTH-1:0] w_rdata;

   // in_ready looks only at registered level, so a pop never opens a slot same-cycle.
   assign w_in_ready  = (r_level != LVL_W'(DEPTH));
   assign w_out_valid = (r_level != '0);
   assign w_push      = io_bus.in_valid && w_in_ready && !i_flush;
   assign w_pop       = w_out_valid && io_bus.out_ready && !i_flush;

   comb3_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({io_bus.in_a, io_bus.in_b}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // Stall counter survives flush; only reset clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (io_bus.in_valid && !w_in_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = w_out_valid;
   assign io_bus.out_a     = w_out_valid ? w_rdata[2*WIDTH-1:WIDTH] : '0;
   assign io_bus.out_b     = w_out_valid ? w_rdata[WIDTH-1:0] : '0;
   assign o_level          = r_level;
   assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_comb3_feeder.sv
// Directed bench for comb3_feeder with hand-computed expectations.
module tb_comb3_feeder;
   import comb3_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [2:0] level;
   logic [7:0] stall_cnt;
   int         checks;
   int         failures;

   comb3_feeder_if #(.WIDTH(4)) bus ();

   comb3_feeder #(
      .WIDTH (4),
      .DEPTH (4),
      .CNT_W (8)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .io_bus      (bus.slave),
      .o_level     (level),
      .o_stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 4'h0, 4'h0);
      tick();
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_level", 32'(level), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_out_a", 32'(bus.out_a), 32'd0);
      rst_n = 1'b1;

      // Single push, head held with out_ready low
      drive(1'b1, 4'hF, 4'h2);
      tick();
      drive(1'b0, 4'h0, 4'h0);
      check("t1_out_valid", 32'(bus.out_valid), 32'd1);
      check("t1_out_a", 32'(bus.out_a), 32'hF);
      check("t1_out_b", 32'(bus.out_b), 32'h2);
      check("t1_level", 32'(level), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_hold_a", 32'(bus.out_a), 32'hF);
         check("t1_hold_b", 32'(bus.out_b), 32'h2);
         check("t1_hold_level", 32'(level), 32'd1);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("t1_drain_level", 32'(level), 32'd0);

      // Fill, then stall 5 cycles with a 5th pair offered
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 4'(k), 4'(k));
         tick();
      end
      check("t2_level_full", 32'(level), 32'd4);
      check("t2_in_ready", 32'(bus.in_ready), 32'd0);
      check("t2_stall0", 32'(stall_cnt), 32'd0);
      drive(1'b1, 4'h5, 4'h5);
      for (int i = 0; i < 5; i++) tick();
      drive(1'b0, 4'h0, 4'h0);
      check("t2_stall5", 32'(stall_cnt), 32'd5);
      check("t2_level_still", 32'(level), 32'd4);

      // Drain in order; in_ready returns after first pop
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("t3_pop_a", 32'(bus.out_a), 32'(k));
         check("t3_pop_b", 32'(bus.out_b), 32'(k));
         tick();
         if (k == 1) check("t3_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
      end
      bus.out_ready = 1'b0;
      check("t3_out_valid", 32'(bus.out_valid), 32'd0);
      check("t3_out_a_zero", 32'(bus.out_a), 32'd0);
      check("t3_out_b_zero", 32'(bus.out_b), 32'd0);
      check("t3_level", 32'(level), 32'd0);

      // Level 2, then 8 cycles of push+pop streaming
      for (int k = 1; k <= 2; k++) begin
         drive(1'b1, 4'(k), 4'(k));
         tick();
      end
      check("t4_level2", 32'(level), 32'd2);
      bus.out_ready = 1'b1;
      for (int k = 3; k <= 10; k++) begin
         drive(1'b1, 4'(k), 4'(k));
         check("t4_head_a", 32'(bus.out_a), 32'(k - 2));
         check("t4_head_b", 32'(bus.out_b), 32'(k - 2));
         tick();
         check("t4_level", 32'(level), 32'd2);
      end
      bus.out_ready = 1'b0;
      check("t4_tail_head", 32'(bus.out_a), 32'd9);

      // Level 3, flush with a push offered
      drive(1'b1, 4'hB, 4'hB);
      tick();
      check("t5_level3", 32'(level), 32'd3);
      drive(1'b1, 4'hC, 4'hC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 4'h0, 4'h0);
      check("t5_level", 32'(level), 32'd0);
      check("t5_out_valid", 32'(bus.out_valid), 32'd0);
      check("t5_in_ready", 32'(bus.in_ready), 32'd1);
      check("t5_stall_kept", 32'(stall_cnt), 32'd5);
      drive(1'b1, 4'hD, 4'hD);
      tick();
      check("t5_head_after_flush", 32'(bus.out_a), 32'hD);
      check("t5_level1", 32'(level), 32'd1);
      drive(1'b1, 4'hE, 4'hE);
      tick();
      drive(1'b0, 4'h0, 4'h0);
      tick();
      drive(1'b1, 4'hF, 4'hF);
      tick();
      drive(1'b0, 4'h0, 4'h0);
      check("t6_level3", 32'(level), 32'd3);

      // Asynchronous reset pulse between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(bus.out_valid), 32'd0);
      check("t6_async_level", 32'(level), 32'd0);
      check("t6_async_ready", 32'(bus.in_ready), 32'd1);
      check("t6_async_stall", 32'(stall_cnt), 32'd0);
      check("t6_async_out_a", 32'(bus.out_a), 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 4'h7, 4'h9);
      tick();
      drive(1'b0, 4'h0, 4'h0);
      check("t6_head_a", 32'(bus.out_a), 32'h7);
      check("t6_head_b", 32'(bus.out_b), 32'h9);
      check("t6_level", 32'(level), 32'd1);

      // Fill and hold in_valid long enough to saturate the stall counter
      drive(1'b1, 4'h1, 4'h1);
      for (int i = 0; i < 303; i++) tick();
      drive(1'b0, 4'h0, 4'h0);
      check("t7_stall_sat", 32'(stall_cnt), 32'hFF);
      check("t7_level", 32'(level), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
